// File: rtl/pdu_pkg.sv
// pdu_pkg: shared constants for the PDU switch/button debouncer.
package pdu_pkg;
  localparam int unsigned DB_CYCLES = 500000;
  localparam int CNT_W = 20;
  localparam int N_CH = 8;
  localparam int IN_W = 5;
  localparam int CH_RUN = 0;
  localparam int CH_STEP = 1;
  localparam int CH_VALID = 2;
  localparam int CH_IN0 = 3;
endpackage

// File: rtl/pdu_debounce_if.sv
// pdu_debounce_if: raw switch inputs and debounced outputs of the PDU debouncer.
interface pdu_debounce_if;
  import pdu_pkg::*;
  logic raw_run, raw_step, raw_valid;
  logic [IN_W-1:0] raw_in;
  logic run, step, valid;
  logic [IN_W-1:0] in;
  logic [N_CH-1:0] rise, fall;
  logic busy;
  modport master (output raw_run, raw_step, raw_valid, raw_in,
                  input run, step, valid, in, rise, fall, busy);
  modport slave (input raw_run, raw_step, raw_valid, raw_in,
                 output run, step, valid, in, rise, fall, busy);
endinterface

// File: rtl/pdu_debounce_ch.sv
// debounce_ch: one channel -- 2-flop synchronizer, stability counter, accepted level and edge pulses.
module debounce_ch #(
  parameter int unsigned DB_CYCLES = pdu_pkg::DB_CYCLES,
  parameter int CNT_W = pdu_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);
  logic s1_q, s2_q, stable_q, stable_d, rise_q, rise_d, fall_q, fall_d, diff, done;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // any sample matching the accepted level restarts the count
  always_comb begin
    diff = s2_q != stable_q;
    done = diff && (cnt_q == CNT_W'(DB_CYCLES - 1));
    cnt_d = (!diff || done) ? '0 : cnt_q + CNT_W'(1);
    stable_d = done ? s2_q : stable_q;
    rise_d = done && s2_q;
    fall_d = done && !s2_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      stable_q <= 1'b0;
      cnt_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign level_o = stable_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign busy_o = |cnt_q;
endmodule

// File: rtl/pdu_debounce.sv
// pdu_debounce: eight debounced channels {in[4:0], valid, step, run} feeding the debug unit.
module pdu_debounce #(
  parameter int unsigned DB_CYCLES = pdu_pkg::DB_CYCLES,
  parameter int CNT_W = pdu_pkg::CNT_W
) (
  input logic clk,
  input logic rst,
  pdu_debounce_if.slave bus
);
  localparam int N = pdu_pkg::N_CH;
  localparam int IN0 = pdu_pkg::CH_IN0;
  localparam int IW = pdu_pkg::IN_W;
  logic [N-1:0] raw, lvl, rise, fall, bsy;
  assign raw = {bus.raw_in, bus.raw_valid, bus.raw_step, bus.raw_run};
  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_ch #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch (
      .clk(clk),
      .rst(rst),
      .raw_i(raw[i]),
      .level_o(lvl[i]),
      .rise_o(rise[i]),
      .fall_o(fall[i]),
      .busy_o(bsy[i])
    );
  end
  assign bus.run = lvl[pdu_pkg::CH_RUN];
  assign bus.step = lvl[pdu_pkg::CH_STEP];
  assign bus.valid = lvl[pdu_pkg::CH_VALID];
  assign bus.in = lvl[IN0 +: IW];
  assign bus.rise = rise;
  assign bus.fall = fall;
  assign bus.busy = |bsy;
endmodule

// File: tb/tb_pdu_debounce.sv
// tb_pdu_debounce: directed stimulus with a pulse scoreboard, DB_CYCLES=4.
module tb_pdu_debounce;
  typedef struct {
    int cyc;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] lvl;
  } ev_t;
  logic clk = 1'b0;
  logic rst;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  ev_t sb[$];
  ev_t mon_e;
  logic [7:0] lvl;
  pdu_debounce_if bus();
  pdu_debounce #(.DB_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign lvl = {bus.in, bus.valid, bus.step, bus.run};
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cyc=%0d", n, a, e, cyc);
    end
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(logic [7:0] r, logic [7:0] f, logic [7:0] l);
    ev_t e;
    e.cyc = cyc + 6;
    e.rise = r;
    e.fall = f;
    e.lvl = l;
    sb.push_back(e);
  endtask
  always @(negedge clk) begin
    if ((bus.rise | bus.fall) != 8'h00) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse rise=%0h fall=%0h required=none at cyc=%0d", bus.rise, bus.fall, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("ev_cyc", cyc, mon_e.cyc);
        chk("ev_rise", {24'h0, bus.rise}, {24'h0, mon_e.rise});
        chk("ev_fall", {24'h0, bus.fall}, {24'h0, mon_e.fall});
        chk("ev_lvl", {24'h0, lvl}, {24'h0, mon_e.lvl});
      end
    end
  end
  initial begin
    rst = 1'b1;
    bus.raw_run = 1'b0;
    bus.raw_step = 1'b0;
    bus.raw_valid = 1'b0;
    bus.raw_in = 5'h1F;
    repeat (3) tick();
    chk("rst_lvl", {24'h0, lvl}, 32'h0);
    chk("rst_pulse", {16'h0, bus.rise, bus.fall}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    rst = 1'b0;
    push(8'hF8, 8'h00, 8'hF8);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("in_hold", {27'h0, bus.in}, 32'h0);
    end
    repeat (6) tick();
    chk("busy_idle", {31'h0, bus.busy}, 32'h0);
    bus.raw_step = 1'b1;
    repeat (3) tick();
    bus.raw_step = 1'b0;
    tick();
    chk("glitch_busy", {31'h0, bus.busy}, 32'h1);
    repeat (4) tick();
    chk("glitch_step", {31'h0, bus.step}, 32'h0);
    chk("glitch_busy_clr", {31'h0, bus.busy}, 32'h0);
    bus.raw_step = 1'b1;
    tick();
    bus.raw_step = 1'b0;
    tick();
    bus.raw_step = 1'b1;
    tick();
    bus.raw_step = 1'b0;
    tick();
    bus.raw_step = 1'b1;
    push(8'h02, 8'h00, 8'hFA);
    repeat (10) tick();
    chk("bounce_step", {31'h0, bus.step}, 32'h1);
    bus.raw_step = 1'b0;
    push(8'h00, 8'h02, 8'hF8);
    repeat (10) tick();
    bus.raw_run = 1'b1;
    bus.raw_valid = 1'b1;
    push(8'h05, 8'h00, 8'hFD);
    repeat (10) tick();
    bus.raw_in = 5'h1E;
    push(8'h00, 8'h08, 8'hF5);
    repeat (10) tick();
    bus.raw_in = 5'h1F;
    repeat (4) tick();
    chk("midcount_busy", {31'h0, bus.busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'h0, bus.busy}, 32'h0);
    chk("midrst_lvl", {24'h0, lvl}, 32'h0);
    repeat (2) tick();
    bus.raw_in = 5'h1E;
    rst = 1'b0;
    push(8'hF5, 8'h00, 8'hF5);
    repeat (10) tick();
    chk("in0_discarded", {27'h0, bus.in}, 32'h1E);
    chk("sb_empty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pdu_debounce.md
PDU_DEBOUNCE -- requirements
Module: pdu_debounce

Interface
REQ-001 Parameter: DB_CYCLES, 20'd500000, number of consecutive stable synchronized samples required to accept a new level (5 ms at 100 MHz); legal range 2..2^CNT_W-1.
REQ-002 Parameter: CNT_W, 20, width of each per-channel debounce counter.
REQ-003 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: raw_run  input  1  unsynchronized run slide switch.
REQ-006 Port: raw_step  input  1  unsynchronized step push button.
REQ-007 Port: raw_valid  input  1  unsynchronized valid slide switch.
REQ-008 Port: raw_in  input  5  unsynchronized data switches.
REQ-009 Port: run, step, valid  output  1 each  debounced levels, driving the debug unit's run/step/valid inputs.
REQ-010 Port: in  output  5  debounced levels of raw_in, driving the debug unit's 5-bit in input.
REQ-011 Port: rise  output  8  one-cycle pulse per channel on accepted 0->1; bit order {in[4:0], valid, step, run} = bits [7:0].
REQ-012 Port: fall  output  8  one-cycle pulse per channel on accepted 1->0; same bit order as rise.
REQ-013 Port: busy  output  1  high while any channel counter is non-zero.

Function
REQ-014 The block SHALL implement 8 independent channels, each with a 2-flop synchronizer (s1, s2), a stable-level register and a CNT_W-bit counter.
REQ-015 Each cycle, s2 equal to stable: counter SHALL clear to 0.
REQ-016 Each cycle, s2 differs from stable and counter < DB_CYCLES-1: counter SHALL increment by 1.
REQ-017 Each cycle, s2 differs from stable and counter == DB_CYCLES-1: stable SHALL take s2, counter SHALL clear, and the matching rise or fall bit SHALL be high for exactly that following cycle.
REQ-018 Latency: raw level settled before edge 1 SHALL appear on the output after edge DB_CYCLES+2, with the pulse coincident with the level change.
REQ-019 A raw excursion lasting fewer than DB_CYCLES synchronized cycles SHALL produce no output change and no pulse.
REQ-020 Any bounce back to the stable level SHALL restart the count from 0; counting SHALL never accumulate across bounces.
REQ-021 Rise and fall bits of the same channel SHALL never be high together; different channels MAY pulse in the same cycle.
REQ-022 The counter SHALL never exceed DB_CYCLES-1; no wrap-around is permitted.
REQ-023 busy SHALL be the combinational OR of (counter != 0) over all channels.

Reset
REQ-024 While rst is high: s1, s2, stable, counters, rise, fall and busy SHALL all be 0, regardless of the raw inputs.
REQ-025 Reset asserted mid-count SHALL discard the count, with no pulse issued.
REQ-026 A raw input held high through reset release SHALL be accepted DB_CYCLES+2 cycles after release, together with a rise pulse.

Structure
REQ-027 DB_CYCLES default, CNT_W and the channel bit-order indices (CH_RUN=0, CH_STEP=1, CH_VALID=2, CH_IN0=3) SHALL live in shared package pdu_pkg.
REQ-028 One sub-module, debounce_ch (single channel: synchronizer, counter, stable register, rise/fall), SHALL be instantiated 8 times by pdu_debounce.
REQ-029 The debounce_ch outputs SHALL be registered; the only combinational output logic is busy.

Verification (bench uses DB_CYCLES=4)
REQ-030 Reset with raw_in=5'h1F -> after release, in=0 for 5 cycles; in=5'h1F and rise[7:3]=5'h1F for one cycle after edge 6.
REQ-031 raw_step high for 3 cycles, then low -> step stays 0; rise[1] and fall[1] stay 0; busy rises, then returns to 0.
REQ-032 raw_step bounces 1,0,1,0,1 for one cycle each, then holds 1 -> exactly one rise[1] pulse, 6 cycles after the final 0->1.
REQ-033 raw_run and raw_valid toggle 0->1 on the same edge -> rise[0] and rise[2] pulse in the same cycle; run=valid=1.
REQ-034 rst asserted 2 cycles into a raw_in[0] 0->1 count -> in[0] stays 0; no pulse; busy=0 during reset.
REQ-035 Accepted raw_step 1->0 -> fall[1] pulse for one cycle; rise[1]=0 throughout.
